// File: rtl/pe_core_ctrl.sv
// Sequencer for a single 3x3 PE_core: serial weight load, bias load, then
// feature column streaming with a token delay line that flags valid results.
module pe_core_ctrl #(
    parameter int FEATURE_WIDTH = 16,
    parameter int WEIGHT_WIDTH  = 16,
    parameter int BIAS_WIDTH    = 32,
    parameter int KSIZE         = 3,
    parameter int PIPE_LAT      = 6,
    parameter int COL_W         = 12
) (
    input  logic                             DSP_clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [COL_W-1:0]                 cfg_col_num,
    input  logic                             cfg_use_bias,
    input  logic [WEIGHT_WIDTH-1:0]          w_data,
    input  logic                             w_valid,
    output logic                             w_ready,
    input  logic [BIAS_WIDTH-1:0]            b_data,
    input  logic                             b_valid,
    output logic                             b_ready,
    input  logic [FEATURE_WIDTH*KSIZE-1:0]   f_data,
    input  logic                             f_valid,
    output logic                             f_ready,
    output logic [WEIGHT_WIDTH-1:0]          pe_weight,
    output logic                             pe_weight_valid,
    output logic [BIAS_WIDTH-1:0]            pe_bias,
    output logic                             pe_bias_valid,
    output logic [FEATURE_WIDTH*KSIZE-1:0]   pe_feature_in,
    output logic                             pe_pulse,
    output logic                             pe_bias_or_adder_feature,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             done
);

    localparam int NW  = KSIZE * KSIZE;
    localparam int WCW = $clog2(NW);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, RUN, DRAIN} state_t;

    state_t              state, state_next;
    logic [COL_W-1:0]    col_num;
    logic [COL_W-1:0]    col_cnt;
    logic [WCW-1:0]      w_cnt;
    logic [PIPE_LAT-1:0] tok_line;
    logic                w_hs, b_hs, f_hs;
    logic                token;
    logic                short_job;
    logic                done_next;

    assign w_hs      = w_valid & w_ready;
    assign b_hs      = b_valid & b_ready;
    assign f_hs      = f_valid & f_ready;
    assign token     = (col_cnt >= COL_W'(KSIZE - 1));
    assign short_job = (cfg_col_num < COL_W'(KSIZE));
    assign busy      = (state != IDLE);

    always_ff @(posedge DSP_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        w_ready    = 1'b0;
        b_ready    = 1'b0;
        f_ready    = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (short_job) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = LOAD_W;
                    end
                end
            end
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && (w_cnt == WCW'(NW - 1))) begin
                    state_next = LOAD_B;
                end
            end
            LOAD_B: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (col_cnt < col_num) begin
                    f_ready = 1'b1;
                    if (f_valid && (col_cnt == col_num - COL_W'(1))) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last accepted column always carries a token, so an
                // empty line means every result has left the core.
                if (tok_line == '0) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge DSP_clk) begin
        if (rst) begin
            col_num                  <= '0;
            col_cnt                  <= '0;
            w_cnt                    <= '0;
            tok_line                 <= '0;
            pe_weight                <= '0;
            pe_weight_valid          <= 1'b0;
            pe_bias                  <= '0;
            pe_bias_valid            <= 1'b0;
            pe_feature_in            <= '0;
            pe_pulse                 <= 1'b0;
            pe_bias_or_adder_feature <= 1'b0;
            out_valid                <= 1'b0;
            done                     <= 1'b0;
        end else begin
            done            <= done_next;
            pe_weight_valid <= w_hs;
            pe_bias_valid   <= b_hs;
            pe_pulse        <= f_hs;
            // One stage here plus out_valid's register gives PIPE_LAT cycles
            // between pe_pulse and out_valid.
            tok_line  <= {tok_line[PIPE_LAT-2:0], f_hs & token};
            out_valid <= tok_line[PIPE_LAT-1];
            if (w_hs) begin
                pe_weight <= w_data;
                w_cnt     <= w_cnt + WCW'(1);
            end
            if (b_hs) begin
                pe_bias <= b_data;
            end
            if (f_hs) begin
                pe_feature_in <= f_data;
                col_cnt       <= col_cnt + COL_W'(1);
            end
            if (state == IDLE && start) begin
                col_num                  <= cfg_col_num;
                pe_bias_or_adder_feature <= cfg_use_bias;
                col_cnt                  <= '0;
                w_cnt                    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pe_core_ctrl.sv
// Directed self-checking bench for pe_core_ctrl: reset, full jobs with and
// without bubbles, short jobs, ignored start/bias, and bias/adder mode select.
module tb_pe_core_ctrl;

    localparam int FW = 16;
    localparam int WW = 16;
    localparam int BW = 32;
    localparam int K  = 3;
    localparam int PL = 6;
    localparam int CW = 12;

    logic              DSP_clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CW-1:0]     cfg_col_num = '0;
    logic              cfg_use_bias = 1'b0;
    logic [WW-1:0]     w_data = '0;
    logic              w_valid = 1'b0;
    logic              w_ready;
    logic [BW-1:0]     b_data = '0;
    logic              b_valid = 1'b0;
    logic              b_ready;
    logic [FW*K-1:0]   f_data = '0;
    logic              f_valid = 1'b0;
    logic              f_ready;
    logic [WW-1:0]     pe_weight;
    logic              pe_weight_valid;
    logic [BW-1:0]     pe_bias;
    logic              pe_bias_valid;
    logic [FW*K-1:0]   pe_feature_in;
    logic              pe_pulse;
    logic              pe_bias_or_adder_feature;
    logic              out_valid;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    logic [WW-1:0]   wq[$];
    int              wc_q[$];
    logic [BW-1:0]   bq[$];
    int              bc_q[$];
    int              pulse_q[$];
    logic [FW*K-1:0] feat_q[$];
    int              ov_q[$];
    int              done_q[$];
    bit              rdy_seen;
    int              busy_n;
    int              mode_n;

    pe_core_ctrl #(
        .FEATURE_WIDTH(FW), .WEIGHT_WIDTH(WW), .BIAS_WIDTH(BW),
        .KSIZE(K), .PIPE_LAT(PL), .COL_W(CW)
    ) dut (
        .DSP_clk(DSP_clk), .rst(rst), .start(start),
        .cfg_col_num(cfg_col_num), .cfg_use_bias(cfg_use_bias),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready),
        .pe_weight(pe_weight), .pe_weight_valid(pe_weight_valid),
        .pe_bias(pe_bias), .pe_bias_valid(pe_bias_valid),
        .pe_feature_in(pe_feature_in), .pe_pulse(pe_pulse),
        .pe_bias_or_adder_feature(pe_bias_or_adder_feature),
        .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 DSP_clk = ~DSP_clk;

    always @(posedge DSP_clk) cyc++;

    // Event recorder sampled mid-cycle; cyc tags the cycle an output was visible in.
    always @(negedge DSP_clk) begin
        if (pe_weight_valid) begin wq.push_back(pe_weight); wc_q.push_back(cyc); end
        if (pe_bias_valid) begin bq.push_back(pe_bias); bc_q.push_back(cyc); end
        if (pe_pulse) begin pulse_q.push_back(cyc); feat_q.push_back(pe_feature_in); end
        if (out_valid) ov_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
        if (w_ready || b_ready || f_ready) rdy_seen = 1'b1;
        if (busy) begin
            busy_n++;
            if (pe_bias_or_adder_feature) mode_n++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [FW*K-1:0] col_word(input int i);
        logic [FW-1:0] r0, r1, r2;
        r0 = FW'(3 * i + 1);
        r1 = FW'(3 * i + 2);
        r2 = FW'(3 * i + 3);
        return {r2, r1, r0};
    endfunction

    task automatic tick();
        @(posedge DSP_clk);
        #1;
    endtask

    task automatic clear_mon();
        wq.delete(); wc_q.delete(); bq.delete(); bc_q.delete();
        pulse_q.delete(); feat_q.delete(); ov_q.delete(); done_q.delete();
        rdy_seen = 1'b0;
        busy_n = 0;
        mode_n = 0;
    endtask

    function automatic logic ready_of(input int sel);
        case (sel)
            0:       return w_ready;
            1:       return b_ready;
            default: return f_ready;
        endcase
    endfunction

    // Waits for the selected ready, then lets the handshake edge pass.
    task automatic wait_hs(input int sel, input string name);
        int t;
        t = 0;
        @(negedge DSP_clk);
        while (!ready_of(sel) && t < 100) begin
            @(negedge DSP_clk);
            t++;
        end
        if (!ready_of(sel)) begin
            errors++;
            $display("[TB] FAIL %s_timeout: ready stayed 0, required 1", name);
        end
        tick();
    endtask

    task automatic start_job(input int n, input logic ub);
        cfg_col_num = CW'(n);
        cfg_use_bias = ub;
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic send_weights(input bit gap);
        for (int i = 0; i < K * K; i++) begin
            if (gap) begin w_valid = 1'b0; tick(); end
            w_data = WW'(i + 1);
            w_valid = 1'b1;
            wait_hs(0, "weight");
            w_valid = 1'b0;
        end
    endtask

    task automatic send_bias(input logic [BW-1:0] d);
        b_data = d;
        b_valid = 1'b1;
        wait_hs(1, "bias");
        b_valid = 1'b0;
    endtask

    task automatic send_cols(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap) begin f_valid = 1'b0; tick(); end
            f_data = col_word(i);
            f_valid = 1'b1;
            wait_hs(2, "column");
            f_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_q.size() == 0 && t < 200) begin
            tick();
            t++;
        end
        if (done_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL done_timeout: no done pulse, required one");
        end
        repeat (3) tick();
    endtask

    task automatic run_job(input int n, input logic ub, input bit gap);
        start_job(n, ub);
        send_weights(gap);
        send_bias(BW'(100));
        send_cols(n, gap);
        wait_done();
    endtask

    // Shared expectations for a 5-column job of weights 1..9, bias 100.
    task automatic check_job5(input string tag);
        checks++;
        if (wq.size() !== 9) begin
            errors++;
            $display("[TB] FAIL %s_weight_count: got %0d, required 9", tag, wq.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (wq[i] !== WW'(i + 1)) begin
                    errors++;
                    $display("[TB] FAIL %s_weight%0d: got %0d, required %0d", tag, i, wq[i], i + 1);
                end
            end
        end
        checks++;
        if (bq.size() !== 1 || bq[0] !== BW'(100)) begin
            errors++;
            $display("[TB] FAIL %s_bias: got %0d entries, required one of value 100", tag, bq.size());
        end
        checks++;
        if (pulse_q.size() !== 5) begin
            errors++;
            $display("[TB] FAIL %s_pulse_count: got %0d, required 5", tag, pulse_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (feat_q[i] !== col_word(i)) begin
                    errors++;
                    $display("[TB] FAIL %s_feature%0d: got %h, required %h", tag, i, feat_q[i], col_word(i));
                end
            end
        end
        checks++;
        if (ov_q.size() !== 3) begin
            errors++;
            $display("[TB] FAIL %s_out_valid_count: got %0d, required 3", tag, ov_q.size());
        end else if (pulse_q.size() == 5) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ov_q[i] !== pulse_q[i + 2] + PL) begin
                    errors++;
                    $display("[TB] FAIL %s_out_valid%0d_cycle: got %0d, required %0d", tag, i, ov_q[i], pulse_q[i + 2] + PL);
                end
            end
            checks++;
            if (done_q.size() !== 1 || done_q[0] !== ov_q[2] + 1) begin
                errors++;
                $display("[TB] FAIL %s_done_cycle: got %0d pulses, required one at cycle %0d", tag, done_q.size(), ov_q[2] + 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        @(negedge DSP_clk);
        checks++;
        if ({w_ready, b_ready, f_ready, pe_weight, pe_weight_valid, pe_bias, pe_bias_valid,
             pe_feature_in, pe_pulse, pe_bias_or_adder_feature, out_valid, busy, done} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: some output nonzero, required all 0");
        end
        rst = 1'b0;
        tick();
        // Abort a job after four columns have been accepted.
        start_job(5, 1'b1);
        send_weights(1'b0);
        send_bias(BW'(100));
        send_cols(4, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrun_busy: got %b, required 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_mon();
        @(negedge DSP_clk);
        checks++;
        if ({w_ready, b_ready, f_ready, pe_weight, pe_weight_valid, pe_bias, pe_bias_valid,
             pe_feature_in, pe_pulse, pe_bias_or_adder_feature, out_valid, busy, done} !== '0) begin
            errors++;
            $display("[TB] FAIL midrun_reset_outputs: some output nonzero, required all 0");
        end
        repeat (20) tick();
        checks++;
        if (done_q.size() !== 0 || ov_q.size() !== 0 || busy_n !== 0) begin
            errors++;
            $display("[TB] FAIL abort_quiet: done=%0d out_valid=%0d busy=%0d, required 0 0 0",
                     done_q.size(), ov_q.size(), busy_n);
        end
    endtask

    task automatic test_full_job();
        clear_mon();
        run_job(5, 1'b1, 1'b0);
        check_job5("b2b");
    endtask

    task automatic test_bubbles();
        clear_mon();
        run_job(5, 1'b1, 1'b1);
        check_job5("bubble");
    endtask

    task automatic test_short_job();
        clear_mon();
        w_valid = 1'b1;
        b_valid = 1'b1;
        f_valid = 1'b1;
        start_job(2, 1'b1);
        repeat (5) tick();
        w_valid = 1'b0;
        b_valid = 1'b0;
        f_valid = 1'b0;
        checks++;
        if (done_q.size() !== 1 || done_q[0] !== start_cyc + 1) begin
            errors++;
            $display("[TB] FAIL short_done: got %0d pulses, required one at cycle %0d", done_q.size(), start_cyc + 1);
        end
        checks++;
        if (rdy_seen !== 1'b0 || busy_n !== 0) begin
            errors++;
            $display("[TB] FAIL short_quiet: ready_seen=%b busy_cycles=%0d, required 0 0", rdy_seen, busy_n);
        end
        checks++;
        if (wq.size() + bq.size() + pulse_q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL short_streams: got %0d core transfers, required 0", wq.size() + bq.size() + pulse_q.size());
        end
    endtask

    task automatic test_ignored_inputs();
        clear_mon();
        start_job(5, 1'b1);
        start = 1'b1;
        b_data = BW'(100);
        b_valid = 1'b1;
        send_weights(1'b0);
        start = 1'b0;
        send_bias(BW'(100));
        start = 1'b1;
        send_cols(5, 1'b0);
        start = 1'b0;
        wait_done();
        check_job5("ignored");
        checks++;
        if (bc_q.size() !== 1 || wc_q.size() !== 9 || bc_q[0] !== wc_q[8] + 1) begin
            errors++;
            $display("[TB] FAIL bias_after_weights: bias entries %0d, required one right after weight 9", bc_q.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_ignored_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_bias_select();
        clear_mon();
        run_job(3, 1'b0, 1'b0);
        checks++;
        if (busy_n == 0 || mode_n !== 0) begin
            errors++;
            $display("[TB] FAIL adder_mode: bias-select high %0d of %0d busy cycles, required 0 of nonzero", mode_n, busy_n);
        end
        checks++;
        if (ov_q.size() !== 1) begin
            errors++;
            $display("[TB] FAIL col3_results: got %0d, required 1", ov_q.size());
        end
        clear_mon();
        run_job(3, 1'b1, 1'b0);
        checks++;
        if (busy_n == 0 || mode_n !== busy_n) begin
            errors++;
            $display("[TB] FAIL bias_mode: bias-select high %0d of %0d busy cycles, required all", mode_n, busy_n);
        end
        checks++;
        if (pe_bias_or_adder_feature !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bias_mode_hold: got %b, required 1", pe_bias_or_adder_feature);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_full_job();
        test_bubbles();
        test_short_job();
        test_ignored_inputs();
        test_bias_select();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_core_ctrl.md
Name: pe_core_ctrl

Overview:
- Sequencer for one 3x3 PE_core convolution kernel.
- Loads the 9 kernel weights serially into the core's weight shift chain, then loads the bias word.
- Streams feature columns into the core and marks which core outputs are valid convolution results.
- Sits between the layer scheduler / weight buffer / line buffer and a single PE_core instance.

Parameters:
FEATURE_WIDTH, 16, width of one feature element
WEIGHT_WIDTH, 16, width of one weight
BIAS_WIDTH, 32, bias width (FEATURE_WIDTH+WEIGHT_WIDTH)
KSIZE, 3, kernel side; weights per load = KSIZE*KSIZE
PIPE_LAT, 6, cycles from pe_pulse to valid feature_out in PE_core
COL_W, 12, width of column counter

Ports:
DSP_clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a job (sampled only in IDLE)
cfg_col_num  in  COL_W  feature columns in this job; latched on start
cfg_use_bias  in  1  1: add bias; 0: add adder_feature (drives pe_bias_or_adder_feature)
w_data  in  WEIGHT_WIDTH  weight stream data
w_valid  in  1  weight stream valid
w_ready  out  1  weight stream ready
b_data  in  BIAS_WIDTH  bias data
b_valid  in  1  bias valid
b_ready  out  1  bias ready
f_data  in  FEATURE_WIDTH*KSIZE  feature column (row 0 in LSBs)
f_valid  in  1  feature valid
f_ready  out  1  feature ready
pe_weight  out  WEIGHT_WIDTH  to PE_core weight
pe_weight_valid  out  1  to PE_core weight_valid
pe_bias  out  BIAS_WIDTH  to PE_core bias
pe_bias_valid  out  1  to PE_core bias_valid
pe_feature_in  out  FEATURE_WIDTH*KSIZE  to PE_core feature_in
pe_pulse  out  1  to PE_core pulse
pe_bias_or_adder_feature  out  1  latched cfg_use_bias
out_valid  out  1  PE_core feature_out this cycle is a valid result
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at job end

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- On rst:
  - state=IDLE.
  - All outputs 0, including every *_valid, ready, pe_pulse, out_valid, busy and done.
  - Counters and the delay line are cleared.
  - Reset mid-job aborts immediately; no done pulse is produced.
- All pe_* outputs and out_valid are registered.
- States: IDLE, LOAD_W, LOAD_B, RUN, DRAIN.
- IDLE:
  - start=1 latches cfg_col_num and cfg_use_bias, then goes to LOAD_W.
  - If cfg_col_num < KSIZE: go to IDLE with a done pulse the next cycle; no streams are touched.
- LOAD_W:
  - w_ready=1.
  - Each w_valid&w_ready handshake registers w_data onto pe_weight, with pe_weight_valid=1 for exactly one cycle (one cycle after the handshake).
  - Accept order: weight k (k=0..8) ends in core slot k. The bench therefore sends row-major w[0][0]..w[2][2].
  - After the 9th handshake, go to LOAD_B. w_ready drops in the same cycle the 9th handshake registers.
- LOAD_B:
  - b_ready=1.
  - On handshake: pe_bias=b_data, pe_bias_valid=1 for one cycle, then go to RUN.
  - Bias is loaded even when cfg_use_bias=0.
- RUN:
  - f_ready=1 while col_cnt < cfg_col_num.
  - On handshake: pe_feature_in=f_data and pe_pulse=1 for one cycle, registered; col_cnt increments.
  - Bubbles (f_valid=0) produce pe_pulse=0 and hold pe_feature_in.
  - The handshake that accepts the last column goes to DRAIN.
- Result marking:
  - Each accepted column pushes a token into a PIPE_LAT-deep shift register.
  - Token = 1 if the column index >= KSIZE-1, i.e. the 3-column window is full.
  - out_valid = token at the tail, so it is high PIPE_LAT cycles after the corresponding pe_pulse.
  - Number of results per job = cfg_col_num-KSIZE+1.
- DRAIN:
  - Hold until the delay line is empty.
  - Then done=1 for one cycle and go to IDLE; busy drops in the same cycle.
- start outside IDLE is ignored.
- Simultaneous valid on a stream not owned by the current state is ignored (its ready=0).
- pe_bias_or_adder_feature holds the latched value from start until the next start.

Test Plan:
1. Reset mid-RUN after 4 columns -> next cycle all outputs 0, state IDLE, no done; a fresh job then runs normally.
2. start, cfg_col_num=5, weights 1..9 back-to-back, bias 100, 5 columns back-to-back:
   - 9 pe_weight_valid pulses carry 1..9 in order.
   - 1 pe_bias_valid carries 100.
   - 5 pe_pulses occur.
   - out_valid is high exactly 3 cycles, starting PIPE_LAT cycles after the 3rd pe_pulse.
   - done follows one cycle after the last out_valid.
3. Same job with w_valid and f_valid toggled every other cycle -> same data order, pe_pulse only on handshakes, out_valid count=3.
4. cfg_col_num=2 -> done 1 cycle after start; w_ready, b_ready and f_ready never assert.
5. start asserted during LOAD_W and RUN, plus b_valid held high during LOAD_W -> no effect; bias accepted only after the 9th weight.
6. cfg_use_bias=0 -> pe_bias_or_adder_feature=0 for the whole job; with cfg_use_bias=1 on the next job -> 1.
